shared_adder_arb: RTL and testbench



---
 rtl/shared_adder_arb.sv | 156 +++++++++++++++
 tb/tb_shared_adder_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/shared_adder_arb.sv
// ============================================================================
// Module   : shared_adder_arb
// Purpose  : Time-shares one registered adder between NREQ valid/ready requesters.
//            `define ADDARB_RR_EN for round-robin grants; undefined = fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shared_adder_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH:0]          rsp_sum,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDW-1:0]   r_id;
  logic [WIDTH:0]   r_sum;
  logic             r_rsp_valid;
  logic             r_busy;

  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

`ifdef ADDARB_RR_EN
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   w_ptr_nxt;

  // Two passes: indices at/above ptr first, then the wrapped-around low indices.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i] && (i >= int'(r_ptr))) begin
        w_found = 1'b1;
        w_win   = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found = 1'b1;
        w_win   = IDW'(i);
      end
    end
  end

  // Explicit wrap so non-power-of-two NREQ never points past the last requester.
  assign w_ptr_nxt = (w_win == IDW'(NREQ-1)) ? '0 : w_win + IDW'(1);
`else
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found = 1'b1;
        w_win   = IDW'(i);
      end
    end
  end
`endif

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_a = req_a[i*WIDTH +: WIDTH];
        w_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Gated by rst so no grant is advertised while reset is held.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !rst && (r_state == S_IDLE) && w_found && (w_win == IDW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_sum       <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef ADDARB_RR_EN
      r_ptr       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_id    <= w_win;
`ifdef ADDARB_RR_EN
            r_ptr   <= w_ptr_nxt;
`endif
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_sum       <= {1'b0, r_a} + {1'b0, r_b};
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_shared_adder_arb.sv
// ============================================================================
// Module   : tb_shared_adder_arb
// Purpose  : Directed vector bench for shared_adder_arb (either ADDARB_RR_EN build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shared_adder_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [8:0]  rsp_sum;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  shared_adder_arb #(.NREQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_id;
    logic [8:0]  exp_sum;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] a,
                              input logic [31:0] b, input int id, input logic [8:0] s);
    vec_t r;
    r.valid = v; r.a = a; r.b = b; r.exp_id = id; r.exp_sum = s;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge where the response is visible.
  task automatic run_vec(input vec_t v, input int idx);
    logic [3:0] exp_rdy;
    req_valid = v.valid;
    req_a     = v.a;
    req_b     = v.b;
    rsp_ready = 1'b1;
    #1;
    exp_rdy = 4'b0001 << v.exp_id;
    chk($sformatf("v%0d_grant", idx), {28'd0, req_ready}, {28'd0, exp_rdy});
    chk($sformatf("v%0d_idle_busy", idx), {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d_calc_valid", idx), {31'd0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d_calc_ready", idx), {28'd0, req_ready}, 32'd0);
    chk($sformatf("v%0d_calc_busy", idx), {31'd0, busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d_rsp_valid", idx), {31'd0, rsp_valid}, 32'd1);
    chk($sformatf("v%0d_rsp_id", idx), {30'd0, rsp_id}, 32'(v.exp_id));
    chk($sformatf("v%0d_rsp_sum", idx), {23'd0, rsp_sum}, {23'd0, v.exp_sum});
  endtask

  initial begin
`ifdef ADDARB_RR_EN
    vecs[0]  = mk(4'hF, 32'h40302010, 32'h04030201, 0, 9'h011);
    vecs[1]  = mk(4'hF, 32'h40302010, 32'h04030201, 1, 9'h022);
    vecs[2]  = mk(4'hF, 32'h40302010, 32'h04030201, 2, 9'h033);
    vecs[3]  = mk(4'hF, 32'h40302010, 32'h04030201, 3, 9'h044);
    vecs[4]  = mk(4'hF, 32'h40302010, 32'h04030201, 0, 9'h011);
    vecs[9]  = mk(4'h9, 32'h7F0000AA, 32'h80000056, 3, 9'h0FF);
    vecs[10] = mk(4'h9, 32'h7F0000AA, 32'h80000056, 0, 9'h100);
`else
    vecs[0]  = mk(4'hF, 32'h40302010, 32'h04030201, 0, 9'h011);
    vecs[1]  = mk(4'hF, 32'h40302010, 32'h04030201, 0, 9'h011);
    vecs[2]  = mk(4'hF, 32'h40302010, 32'h04030201, 0, 9'h011);
    vecs[3]  = mk(4'hF, 32'h40302010, 32'h04030201, 0, 9'h011);
    vecs[4]  = mk(4'hF, 32'h40302010, 32'h04030201, 0, 9'h011);
    vecs[9]  = mk(4'h9, 32'h7F0000AA, 32'h80000056, 0, 9'h100);
    vecs[10] = mk(4'h9, 32'h7F0000AA, 32'h80000056, 0, 9'h100);
`endif
    vecs[5]  = mk(4'h2, 32'h0000FF00, 32'h00000100, 1, 9'h100);
    vecs[6]  = mk(4'h2, 32'h00000100, 32'h00000100, 1, 9'h002);
    vecs[7]  = mk(4'h2, 32'h00000000, 32'h00000000, 1, 9'h000);
    vecs[8]  = mk(4'h4, 32'h00050000, 32'h00070000, 2, 9'h00C);
    vecs[11] = mk(4'h4, 32'h00C80000, 32'h00C80000, 2, 9'h190);

    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = 32'h40302010;
    req_b     = 32'h04030201;
    rsp_ready = 1'b0;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_sum", {23'd0, rsp_sum}, 32'd0);
      chk("rst_id", {30'd0, rsp_id}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      run_vec(vecs[i], i);
    end

    // Backpressure: response held for 5 cycles while requester 0 keeps asking.
    @(negedge clk);
    req_valid = 4'h1;
    req_a     = 32'h00000009;
    req_b     = 32'h00000003;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", {28'd0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_id", {30'd0, rsp_id}, 32'd0);
      chk("bp_sum", {23'd0, rsp_sum}, 32'h00C);
      chk("bp_ready", {28'd0, req_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_done_busy", {31'd0, busy}, 32'd0);
    chk("bp_next_grant", {28'd0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'h0;
    @(posedge clk);
    @(negedge clk);
    chk("bp2_sum", {23'd0, rsp_sum}, 32'h00C);
    chk("bp2_valid", {31'd0, rsp_valid}, 32'd1);

    // Mid-operation reset while in CALC.
    @(negedge clk);
    req_valid = 4'h5;
    req_a     = 32'h00030002;
    req_b     = 32'h00100005;
    #1;
`ifdef ADDARB_RR_EN
    chk("mr_pre_grant", {28'd0, req_ready}, 32'h4);
`else
    chk("mr_pre_grant", {28'd0, req_ready}, 32'h1);
`endif
    @(posedge clk);
    @(negedge clk);
    chk("mr_calc_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mr_ready", {28'd0, req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mr_hold_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mr_post_grant", {28'd0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("mr_calc_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("mr_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("mr_rsp_sum", {23'd0, rsp_sum}, 32'h007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
